// File: rtl/nco_ctrl_pkg.sv
// Shared types and defaults for the NCO sweep sequencer.
// Holds the FSM state encoding and the zero-to-one count helper.
package nco_ctrl_pkg;

    localparam int DEF_PHW  = 16;
    localparam int DEF_CNTW = 16;
    localparam int DEF_STW  = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DWELL,
        DONE
    } state_t;

    // A count of zero is treated as one step / one sample.
    function automatic logic [31:0] nz1(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/nco_sample_cnt.sv
// Valid-sample counter with synchronous clear and terminal-count flag.
// hit marks the enabled cycle that brings the count up to term.
module nco_sample_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         hit
);

    assign hit = en && ((cnt + W'(1)) == term);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency sweep sequencer driving an NCO phase increment and clock enable.
// Each step discards settle samples, then flags a dwell window for capture.
module nco_sweep_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int PHW  = DEF_PHW,
    parameter int CNTW = DEF_CNTW,
    parameter int STW  = DEF_STW
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            abort,
    input  logic [PHW-1:0]  f_start,
    input  logic [PHW-1:0]  f_step,
    input  logic [STW-1:0]  n_steps,
    input  logic [CNTW-1:0] settle_n,
    input  logic [CNTW-1:0] dwell_n,
    input  logic            nco_valid,
    output logic [PHW-1:0]  phi_inc_o,
    output logic            clken_o,
    output logic            sample_en,
    output logic [STW-1:0]  step_idx,
    output logic            busy,
    output logic            done
);

    state_t state_q, state_d;

    logic [PHW-1:0]  fstep_q;
    logic [STW-1:0]  nsteps_q;
    logic [CNTW-1:0] settle_q;
    logic [CNTW-1:0] dwell_q;

    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] term;
    logic            cnt_en;
    logic            cnt_clr;
    logic            hit;
    logic            load;
    logic            adv;
    logic            last;

    assign last = (step_idx == (nsteps_q - STW'(1)));

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        adv     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = SETTLE;
                    load    = 1'b1;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if ((settle_q == '0) || hit) begin
                    state_d = DWELL;
                end
            end
            DWELL: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (hit) begin
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        state_d = SETTLE;
                        adv     = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fstep_q   <= '0;
            nsteps_q  <= '0;
            settle_q  <= '0;
            dwell_q   <= '0;
            phi_inc_o <= '0;
            step_idx  <= '0;
        end else if (load) begin
            fstep_q   <= f_step;
            nsteps_q  <= STW'(nz1(32'(n_steps)));
            settle_q  <= settle_n;
            dwell_q   <= CNTW'(nz1(32'(dwell_n)));
            phi_inc_o <= f_start;
            step_idx  <= '0;
        end else if (adv) begin
            phi_inc_o <= phi_inc_o + fstep_q;
            step_idx  <= step_idx + STW'(1);
        end
    end

    // One counter serves both phases; any state change restarts it.
    assign cnt_clr = (state_d != state_q);
    assign cnt_en  = nco_valid && ((state_q == SETTLE) || (state_q == DWELL));
    assign term    = (state_q == SETTLE) ? settle_q : dwell_q;

    nco_sample_cnt #(
        .W(CNTW)
    ) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .term    (term),
        .cnt     (cnt),
        .hit     (hit)
    );

    assign busy      = (state_q == SETTLE) || (state_q == DWELL);
    assign clken_o   = busy;
    assign sample_en = (state_q == DWELL) && nco_valid;
    assign done      = (state_q == DONE);

endmodule
